// File: rtl/usi_multi_master_bus_if.sv
// rtl/usi_multi_master_bus_if.sv - master-side and slave-side signal bundle of the USI/F interconnect
interface usi_multi_master_bus_if #(
    parameter int pMasterNum  = 2,
    parameter int pSlaveNum   = 9,
    parameter int pBusDataBit = 32,
    parameter int pBusAdrsBit = 16
);
    logic [pMasterNum-1:0]             iMUsiReq;
    logic [pMasterNum-1:0]             iMUsiWEd;
    logic [pMasterNum-1:0]             iMUsiLock;
    logic [pMasterNum*pBusAdrsBit-1:0] iMUsiAdrs;
    logic [pMasterNum*pBusDataBit-1:0] iMUsiWd;
    logic [pBusDataBit-1:0]            oMUsiRd;
    logic [pMasterNum-1:0]             oMUsiAck;
    logic                              oMUsiErr;
    logic [pMasterNum-1:0]             oMUsiGnt;
    logic [pBusAdrsBit-1:0]            oSUsiAdrs;
    logic [pBusDataBit-1:0]            oSUsiWd;
    logic                              oSUsiWCke;
    logic                              oSUsiRCke;
    logic [pSlaveNum-1:0]              oSUsiSel;
    logic [pSlaveNum*pBusDataBit-1:0]  iSUsiRd;
    logic [pSlaveNum-1:0]              iSUsiVd;

    // Environment view: requesting masters plus responding peripheral blocks.
    modport master (
        output iMUsiReq, iMUsiWEd, iMUsiLock, iMUsiAdrs, iMUsiWd, iSUsiRd, iSUsiVd,
        input  oMUsiRd, oMUsiAck, oMUsiErr, oMUsiGnt,
        input  oSUsiAdrs, oSUsiWd, oSUsiWCke, oSUsiRCke, oSUsiSel
    );

    // Interconnect view.
    modport slave (
        input  iMUsiReq, iMUsiWEd, iMUsiLock, iMUsiAdrs, iMUsiWd, iSUsiRd, iSUsiVd,
        output oMUsiRd, oMUsiAck, oMUsiErr, oMUsiGnt,
        output oSUsiAdrs, oSUsiWd, oSUsiWCke, oSUsiRCke, oSUsiSel
    );
endinterface

// File: rtl/usi_multi_master_bus.sv
// rtl/usi_multi_master_bus.sv - round-robin multi-master USI/F interconnect with lock, decode, wait and timeout
module usi_multi_master_bus #(
    parameter int pMasterNum    = 2,
    parameter int pSlaveNum     = 9,
    parameter int pBusDataBit   = 32,
    parameter int pBusAdrsBit   = 16,
    parameter int pBlockAdrsMap = 8,
    parameter int pTimeout      = 16
) (
    input  logic                  iSysClk,
    input  logic                  iSysRst,
    usi_multi_master_bus_if.slave bus
);
    localparam int GW = (pMasterNum > 1) ? $clog2(pMasterNum) : 1;
    localparam int SW = (pSlaveNum > 1) ? $clog2(pSlaveNum) : 1;
    localparam int TW = $clog2(pTimeout);
    localparam logic [TW-1:0] TLAST = TW'(pTimeout - 1);
    localparam logic [GW-1:0] GRST  = GW'(pMasterNum - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_q, last_d;
    logic [GW-1:0]           gidx_q, gidx_d;
    logic [SW-1:0]           sid_q, sid_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    wed_q, wed_d;
    logic [pMasterNum-1:0]   gnt_q, gnt_d;
    logic [pMasterNum-1:0]   ack_q, ack_d;
    logic [pSlaveNum-1:0]    sel_q, sel_d;
    logic [pBusAdrsBit-1:0]  adrs_q, adrs_d;
    logic [pBusDataBit-1:0]  wd_q, wd_d;
    logic [pBusDataBit-1:0]  rd_q, rd_d;
    logic                    err_q, err_d;
    logic                    wcke_q, wcke_d;
    logic                    rcke_q, rcke_d;

    logic                    arb_found;
    logic [GW-1:0]           arb_idx;
    logic [pBusAdrsBit-1:0]  arb_adrs;
    int                      blk;
    logic                    vd_sel;
    logic [pBusDataBit-1:0]  rd_sel;

    assign arb_adrs = bus.iMUsiAdrs[arb_idx*pBusAdrsBit +: pBusAdrsBit];
    assign blk      = int'(arb_adrs[pBusAdrsBit-1 -: pBlockAdrsMap]);
    assign vd_sel   = bus.iSUsiVd[sid_q];
    assign rd_sel   = bus.iSUsiRd[sid_q*pBusDataBit +: pBusDataBit];

    // Pick the winner: a locked previous holder keeps the bus, otherwise first requester after last grant.
    always_comb begin : arb
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        if (bus.iMUsiReq[last_q] && bus.iMUsiLock[last_q]) begin
            arb_found = 1'b1;
            arb_idx   = last_q;
        end else begin
            // Descending scan so the nearest requester after last_q is written last and wins.
            for (int i = pMasterNum; i >= 1; i--) begin
                cand = (int'(last_q) + i) % pMasterNum;
                if (bus.iMUsiReq[cand]) begin
                    arb_found = 1'b1;
                    arb_idx   = GW'(cand);
                end
            end
        end
    end

    // Transfer sequencing and next values of every registered output.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        sid_d   = sid_q;
        timer_d = timer_q;
        wed_d   = wed_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        adrs_d  = adrs_q;
        wd_d    = wd_q;
        ack_d   = '0;
        rd_d    = '0;
        err_d   = 1'b0;
        wcke_d  = 1'b0;
        rcke_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gidx_d          = arb_idx;
                    gnt_d           = '0;
                    gnt_d[arb_idx]  = 1'b1;
                    adrs_d          = arb_adrs;
                    wd_d            = bus.iMUsiWd[arb_idx*pBusDataBit +: pBusDataBit];
                    wed_d           = bus.iMUsiWEd[arb_idx];
                    sel_d           = '0;
                    sid_d           = '0;
                    // Block id k+1 addresses slave k; id 0 and ids past the last slave stay unselected.
                    if (blk >= 1 && blk <= pSlaveNum) begin
                        sid_d        = SW'(blk - 1);
                        sel_d[sid_d] = 1'b1;
                        wcke_d       = wed_d;
                        rcke_d       = ~wed_d;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                if (sel_q == '0) begin
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else if (wed_q) begin
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else if (vd_sel) begin
                    rd_d    = rd_sel;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (vd_sel) begin
                    rd_d    = rd_sel;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else if (timer_q == TLAST) begin
                    err_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = gidx_q;
                gnt_d   = '0;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state_q <= IDLE;
            last_q  <= GRST;
            gidx_q  <= '0;
            sid_q   <= '0;
            timer_q <= '0;
            wed_q   <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            sel_q   <= '0;
            adrs_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            wcke_q  <= 1'b0;
            rcke_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            sid_q   <= sid_d;
            timer_q <= timer_d;
            wed_q   <= wed_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            adrs_q  <= adrs_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            wcke_q  <= wcke_d;
            rcke_q  <= rcke_d;
        end
    end

    assign bus.oMUsiRd   = rd_q;
    assign bus.oMUsiAck  = ack_q;
    assign bus.oMUsiErr  = err_q;
    assign bus.oMUsiGnt  = gnt_q;
    assign bus.oSUsiAdrs = adrs_q;
    assign bus.oSUsiWd   = wd_q;
    assign bus.oSUsiWCke = wcke_q;
    assign bus.oSUsiRCke = rcke_q;
    assign bus.oSUsiSel  = sel_q;
endmodule
